imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the core's instruction bank. It accepts a byte stream through a valid/ready handshake, assembles little-endian instruction words and writes them to consecutive instruction addresses starting at 0. It verifies a trailing XOR checksum and holds the core in reset until a load completes cleanly. It drives the write port of the instruction `reg_bank_mono`, which the core itself only ever reads.

## Interface
- `REG_WIDTH`, 32, instruction word width in bits; must be a multiple of 8.
- `NUM_INSTR`, 64, instruction bank depth; must be in the range 1..255.
- `INSTR_SELECT` (localparam) = `$clog2(NUM_INSTR)`.
- `BYTES` (localparam) = `REG_WIDTH/8`.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `i_start`  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `i_valid`  input  1  `i_byte` holds a byte.
- `i_byte`  input  8  stream byte.
- `o_ready`  output  1  loader will accept `i_byte` this cycle.
- `o_write_enable`  output  1  instruction bank write strobe.
- `o_select`  output  INSTR_SELECT  instruction bank address.
- `o_write_data`  output  REG_WIDTH  instruction word to write.
- `o_core_hold`  output  1  high means the core must be held in reset.
- `o_done`  output  1  level signal: a load completed and the checksum matched.
- `o_error`  output  1  level signal: the load was aborted.
- `o_err_code`  output  2  error cause: 0 = none, 1 = bad header, 2 = bad checksum.

## Operation
- Stream format:
  - One header byte N, the number of words.
  - N×BYTES payload bytes. Each word is sent least-significant byte first, so the first byte lands in bits [7:0].
  - One checksum byte, equal to the XOR of all payload bytes. The header is excluded from the checksum.
- A byte transfers on a rising edge where `i_valid && o_ready`. Bytes offered while `o_ready`=0 are not consumed; the source holds them.
- States and transitions:
  - IDLE: `o_ready`=0. `i_start` moves to HEADER.
  - HEADER: `o_ready`=1.
    - On transfer, if N==0 or N>NUM_INSTR, go to ERROR with code 1.
    - Otherwise latch N, clear the word index, byte index and checksum accumulator, and go to DATA.
  - DATA: `o_ready`=1. Each transfer is shifted into byte lane `byte_idx` and XORed into the accumulator. The transfer with `byte_idx`==BYTES-1 moves to WRITE and clears `byte_idx`.
  - WRITE: `o_ready`=0. Drive `o_write_enable`=1 for exactly one cycle, with `o_select`=`word_idx` and `o_write_data`=assembled word.
    - If `word_idx`==N-1, go to CHECK.
    - Otherwise increment `word_idx` and go to DATA.
  - CHECK: `o_ready`=1. On transfer, if the byte equals the accumulator go to DONE; otherwise go to ERROR with code 2.
  - DONE: `o_done`=1 and `o_core_hold`=0. `i_start` returns to HEADER.
  - ERROR: `o_error`=1 and `o_core_hold`=1. `i_start` returns to HEADER and clears `o_err_code`.
- `o_core_hold`:
  - Is 1 in every state except DONE.
  - Reasserts in the cycle after an `i_start` taken from DONE.
- `i_start` is ignored in HEADER, DATA, WRITE and CHECK.
- Words already written before a checksum failure are not undone; the core stays held.
- `word_idx` never exceeds N-1 ≤ NUM_INSTR-1 and never wraps.
- `o_select` and `o_write_data` are registered. Their value outside WRITE is don't-care, but they must hold stable while the strobe is low.

## Timing
- Reset values: state=IDLE, `o_ready`=0, `o_write_enable`=0, `o_select`=0, `o_write_data`=0, `o_core_hold`=1, `o_done`=0, `o_error`=0, `o_err_code`=0, and all counters and the accumulator = 0.
- Reset in any state, including mid-word, returns to IDLE asynchronously. No write strobe may occur after reset asserts.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- `i_start` sampled at edge t gives HEADER and `o_ready`=1 in cycle t+1.
- The last byte of a word transferred at edge t gives `o_write_enable` high in cycle t+1. `o_ready`=1 again in cycle t+2.
- Maximum throughput is BYTES bytes per BYTES+1 cycles.
- The checksum byte transferred at edge t gives `o_done` or `o_error` high, and `o_core_hold` at its final value, in cycle t+1.
- A header error is reported in the cycle after the header byte transfers.

## Test plan
- Two-word load (REG_WIDTH=32): start, then stream 02,44,33,22,11,DD,CC,BB,AA,44 with `i_valid` always high. Required:
  - Exactly two write strobes: addr 0 = 0x11223344, then addr 1 = 0xAABBCCDD.
  - `o_ready` low on each strobe cycle.
  - Then `o_done`=1, `o_core_hold`=0, `o_err_code`=0.
- Bad checksum: same stream ending in 45. Required: both writes occur, then `o_error`=1, `o_err_code`=2, `o_core_hold`=1, `o_done`=0.
- Bad header: header 00, then (after a restart) header 41 with NUM_INSTR=64. Required: ERROR with code 1 each time and zero write strobes.
- Gappy source: the two-word stream with `i_valid` high only every third cycle. Required: identical writes and result. No byte is consumed twice, and none is consumed while `o_ready`=0.
- Reset mid-word: drive `rst` low after header 01 and bytes 44,33. Required:
  - Immediate IDLE and all reset values.
  - A fresh start followed by 01,78,56,34,12,08 writes addr 0 = 0x12345678 and reaches DONE.
- Full depth and reload: load 64 words with word k = k. Required:
  - The last strobe is at addr 63 and the run ends in DONE.
  - A subsequent `i_start` raises `o_core_hold` the next cycle and re-enters HEADER.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a boot source (master) and the instruction loader (slave).
interface imem_loader_if;
  logic       i_valid;
  logic [7:0] i_byte;
  logic       o_ready;

  modport master (output i_valid, output i_byte, input o_ready);
  modport slave  (input i_valid, input i_byte, output o_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction bank writer: assembles little-endian words from a byte stream,
// writes them from address 0 upward and releases the core only after a matching XOR checksum.
module imem_loader #(
  parameter  int REG_WIDTH    = 32,
  parameter  int NUM_INSTR    = 64,
  localparam int INSTR_SELECT = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
  localparam int BYTES        = REG_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  imem_loader_if.slave            stream,
  output logic                    o_write_enable,
  output logic [INSTR_SELECT-1:0] o_select,
  output logic [REG_WIDTH-1:0]    o_write_data,
  output logic                    o_core_hold,
  output logic                    o_done,
  output logic                    o_error,
  output logic [1:0]              o_err_code
);

  // state    | meaning
  // S_IDLE   | after reset, waiting for i_start
  // S_HEADER | accepting the word-count byte
  // S_DATA   | accepting payload bytes of the current word
  // S_WRITE  | one-cycle write strobe of the assembled word
  // S_CHECK  | accepting the checksum byte
  // S_DONE   | load good, core released
  // S_ERROR  | load aborted, core held
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam int                BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [7:0]        MAX_N     = 8'(NUM_INSTR);
  localparam logic [BIDX_W-1:0] LAST_LANE = BIDX_W'(BYTES - 1);

  state_e                  state_q;
  logic [7:0]              n_q;
  logic [7:0]              acc_q;
  logic [INSTR_SELECT-1:0] word_idx_q;
  logic [BIDX_W-1:0]       byte_idx_q;
  logic [REG_WIDTH-1:0]    word_q;
  logic [REG_WIDTH-1:0]    word_merged;
  logic                    ready_q;
  logic                    we_q;
  logic [INSTR_SELECT-1:0] sel_q;
  logic [REG_WIDTH-1:0]    wdata_q;
  logic                    hold_q;
  logic                    done_q;
  logic                    error_q;
  logic [1:0]              err_q;
  logic                    xfer;

  assign xfer = stream.i_valid && ready_q;

  // The word as it will look once the byte on the bus lands in its lane.
  always_comb begin
    word_merged = word_q;
    word_merged[{byte_idx_q, 3'b000} +: 8] = stream.i_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= 2'd0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state_q <= S_HEADER;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= 2'd0;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (stream.i_byte == 8'd0 || stream.i_byte > MAX_N) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
              err_q   <= 2'd1;
            end else begin
              state_q    <= S_DATA;
              n_q        <= stream.i_byte;
              word_idx_q <= '0;
              byte_idx_q <= '0;
              acc_q      <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_q <= word_merged;
            acc_q  <= acc_q ^ stream.i_byte;
            if (byte_idx_q == LAST_LANE) begin
              state_q    <= S_WRITE;
              byte_idx_q <= '0;
              ready_q    <= 1'b0;
              we_q       <= 1'b1;
              sel_q      <= word_idx_q;
              wdata_q    <= word_merged;
            end else begin
              byte_idx_q <= byte_idx_q + BIDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          ready_q <= 1'b1;
          if (8'(word_idx_q) == n_q - 8'd1) begin
            state_q <= S_CHECK;
          end else begin
            state_q    <= S_DATA;
            word_idx_q <= word_idx_q + INSTR_SELECT'(1);
          end
        end
        S_CHECK: begin
          if (xfer) begin
            ready_q <= 1'b0;
            if (stream.i_byte == acc_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              err_q   <= 2'd2;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stream.o_ready = ready_q;
  assign o_write_enable = we_q;
  assign o_select       = sel_q;
  assign o_write_data   = wdata_q;
  assign o_core_hold    = hold_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_err_code     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and checks them.
module tb_imem_loader;
  localparam int RW = 32;
  localparam int NI = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        o_write_enable;
  logic [5:0]  o_select;
  logic [31:0] o_write_data;
  logic        o_core_hold, o_done, o_error;
  logic [1:0]  o_err_code;

  imem_loader_if bus();

  imem_loader #(.REG_WIDTH(RW), .NUM_INSTR(NI)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .stream         (bus.slave),
    .o_write_enable (o_write_enable),
    .o_select       (o_select),
    .o_write_data   (o_write_data),
    .o_core_hold    (o_core_hold),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_err_code     (o_err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  int xfers  = 0;
  int last_addr = -1;
  logic [5:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stream_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.i_valid && bus.o_ready) xfers++;
    if (o_write_enable) begin
      writes++;
      last_addr = int'(o_select);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h with no write expected", o_select, o_write_data);
      end else begin
        chk("write_addr", 32'(o_select), 32'(exp_addr_q.pop_front()));
        chk("write_data", o_write_data, exp_data_q.pop_front());
        chk("ready_low_on_strobe", 32'(bus.o_ready), 32'd0);
      end
    end
  end

  task automatic push_write(input logic [5:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic do_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    chk("ready_after_start", 32'(bus.o_ready), 32'd1);
    chk("hold_after_start", 32'(o_core_hold), 32'd1);
  endtask

  // Offer every byte of stream_q, idling `gap` cycles before each; returns in the cycle after the last transfer.
  task automatic send(input int gap);
    int  x0;
    int  n;
    bit  acc;
    x0 = xfers;
    foreach (stream_q[i]) begin
      repeat (gap) begin
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.i_valid = 1'b1;
      bus.i_byte  = stream_q[i];
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.o_ready;
        @(posedge clk); #1;
        n++;
        if (!acc && n > 50) begin
          checks++;
          errors++;
          $display("FAIL byte_timeout: byte %0d never accepted within 50 cycles", i);
          bus.i_valid = 1'b0;
          return;
        end
      end
    end
    bus.i_valid = 1'b0;
    chk("xfer_count", 32'(xfers - x0), 32'(stream_q.size()));
  endtask

  task automatic chk_done();
    chk("done", 32'(o_done), 32'd1);
    chk("error_clear", 32'(o_error), 32'd0);
    chk("hold_released", 32'(o_core_hold), 32'd0);
    chk("err_code_none", 32'(o_err_code), 32'd0);
    chk("writes_pending", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic chk_error(input logic [1:0] code);
    chk("error", 32'(o_error), 32'd1);
    chk("done_clear", 32'(o_done), 32'd0);
    chk("hold_kept", 32'(o_core_hold), 32'd1);
    chk("err_code", 32'(o_err_code), 32'(code));
    chk("writes_pending", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_we", 32'(o_write_enable), 32'd0);
    chk("rst_select", 32'(o_select), 32'd0);
    chk("rst_wdata", o_write_data, 32'd0);
    chk("rst_hold", 32'(o_core_hold), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_err_code", 32'(o_err_code), 32'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] cs;
    bus.i_valid = 1'b0;
    bus.i_byte  = 8'h00;
    #12;
    chk_reset_vals();
    @(posedge clk); #1 rst = 1'b1;

    // Two-word load, valid always high.
    do_start();
    w0 = writes;
    stream_q = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
    push_write(6'd0, 32'h1122_3344);
    push_write(6'd1, 32'hAABB_CCDD);
    send(0);
    chk_done();
    chk("two_word_writes", 32'(writes - w0), 32'd2);

    // Bad checksum: writes stick, core stays held.
    do_start();
    chk("done_cleared_on_start", 32'(o_done), 32'd0);
    w0 = writes;
    stream_q = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h45};
    push_write(6'd0, 32'h1122_3344);
    push_write(6'd1, 32'hAABB_CCDD);
    send(0);
    chk_error(2'd2);
    chk("bad_cs_writes", 32'(writes - w0), 32'd2);

    // Bad headers: zero and NUM_INSTR+1.
    do_start();
    chk("err_code_cleared", 32'(o_err_code), 32'd0);
    chk("error_cleared", 32'(o_error), 32'd0);
    w0 = writes;
    stream_q = '{8'h00};
    send(0);
    chk_error(2'd1);
    do_start();
    stream_q = '{8'h41};
    send(0);
    chk_error(2'd1);
    chk("bad_hdr_writes", 32'(writes - w0), 32'd0);

    // Gappy source.
    do_start();
    w0 = writes;
    stream_q = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
    push_write(6'd0, 32'h1122_3344);
    push_write(6'd1, 32'hAABB_CCDD);
    send(2);
    chk_done();
    chk("gappy_writes", 32'(writes - w0), 32'd2);

    // Reset mid-word, then a fresh single-word load.
    do_start();
    stream_q = '{8'h01, 8'h44, 8'h33};
    send(0);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk); #1 rst = 1'b1;
    do_start();
    w0 = writes;
    stream_q = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    push_write(6'd0, 32'h1234_5678);
    send(0);
    chk_done();
    chk("after_reset_writes", 32'(writes - w0), 32'd1);

    // Full depth, then reload from DONE.
    do_start();
    w0 = writes;
    stream_q = '{8'd64};
    cs = 8'h00;
    for (int k = 0; k < NI; k++) begin
      stream_q.push_back(8'(k));
      stream_q.push_back(8'h00);
      stream_q.push_back(8'h00);
      stream_q.push_back(8'h00);
      cs = cs ^ 8'(k);
      push_write(6'(k), 32'(k));
    end
    stream_q.push_back(cs);
    send(0);
    chk_done();
    chk("full_writes", 32'(writes - w0), 32'd64);
    chk("full_last_addr", 32'(last_addr), 32'd63);
    do_start();
    chk("reload_done_cleared", 32'(o_done), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
